// File: rtl/led_serial_dec.sv
// Nibble-serial LED-128 decryption core: inverse of led_serial with the same start/done handshake.
// Each inverse round runs 4 InvMixColumnsSerial cycles, 1 InvShiftRows cycle and 16 InvSubCells/constant cycles.
module led_serial_dec #(
  parameter int unsigned ROUNDS  = 48,
  parameter int unsigned RND_CYC = 21
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] keyi,
  input  logic [63:0]  datai,
  output logic [63:0]  dataq,
  output logic         done,
  output logic         busy
);

  localparam int unsigned STEPS   = ROUNDS / 4;
  localparam int unsigned IMC_CYC = 4;
  localparam int unsigned ISB_CYC = RND_CYC - IMC_CYC - 1;

  localparam logic [3:0] STEP_LAST = 4'(STEPS - 1);
  localparam logic [3:0] IMC_LAST  = 4'(IMC_CYC - 1);
  localparam logic [3:0] ISB_LAST  = 4'(ISB_CYC - 1);
  localparam logic [1:0] RND_LAST  = 2'd3;
  localparam logic [5:0] RC_INIT   = 6'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IMC,
    S_ISR,
    S_ISB,
    S_AK,
    S_FIN
  } fsm_t;

  fsm_t         fsm,   fsm_d;
  logic [63:0]  blk,   blk_d;
  logic [127:0] key,   key_d;
  logic [5:0]   rc,    rc_d;
  logic [3:0]   step,  step_d;
  logic [1:0]   rnd,   rnd_d;
  logic [3:0]   cnt,   cnt_d;
  logic [63:0]  dataq_d;
  logic         done_d;
  logic         busy_d;

  // Nibble idx (raster order) lives at bits [63-4*idx -: 4]; ~idx*4 is its shift from the LSB.
  function automatic logic [3:0] nib_get(input logic [63:0] s, input logic [3:0] idx);
    return 4'(s >> {~idx, 2'b00});
  endfunction

  function automatic logic [63:0] nib_set(input logic [63:0] s, input logic [3:0] idx,
                                          input logic [3:0] n);
    logic [5:0] sh;
    sh = {~idx, 2'b00};
    return (s & ~(64'hF << sh)) | ({60'd0, n} << sh);
  endfunction

  // GF(2^4) multiply by x, reduction polynomial x^4+x+1
  function automatic logic [3:0] gf_x(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  // Multiply by 0xD = x^3+x^2+1, the inverse of 4
  function automatic logic [3:0] gf_d(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf_x(a);
    a4 = gf_x(a2);
    a8 = gf_x(a4);
    return a8 ^ a4 ^ a;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Round constant for nibble idx: fixed key-size column plus the rc column
  function automatic logic [3:0] rc_const(input logic [3:0] idx, input logic [5:0] r);
    logic [3:0] k;
    k = 4'h0;
    if (idx[1:0] == 2'd0) begin
      case (idx[3:2])
        2'd0:    k = 4'h8;
        2'd1:    k = 4'h9;
        2'd2:    k = 4'h2;
        default: k = 4'h3;
      endcase
    end else if (idx[1:0] == 2'd1) begin
      k = idx[2] ? {1'b0, r[2:0]} : {1'b0, r[5:3]};
    end
    return k;
  endfunction

  // One application of A^-1 to every column in parallel
  function automatic logic [63:0] inv_mix(input logic [63:0] s);
    logic [63:0] res;
    logic [3:0]  n0, n1, n2, n3;
    res = s;
    for (int c = 0; c < 4; c++) begin
      n0  = nib_get(s, 4'(c));
      n1  = nib_get(s, 4'(4 + c));
      n2  = nib_get(s, 4'(8 + c));
      n3  = nib_get(s, 4'(12 + c));
      res = nib_set(res, 4'(c),      gf_d(n0 ^ n3 ^ gf_x(n1) ^ gf_x(n2)));
      res = nib_set(res, 4'(4 + c),  n0);
      res = nib_set(res, 4'(8 + c),  n1);
      res = nib_set(res, 4'(12 + c), n2);
    end
    return res;
  endfunction

  // Row r rotated right by r nibbles
  function automatic logic [63:0] inv_shift(input logic [63:0] s);
    logic [63:0] res;
    res = s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res = nib_set(res, 4'(4 * r + c), nib_get(s, 4'(4 * r + ((c + 4 - r) % 4))));
      end
    end
    return res;
  endfunction

  function automatic logic [5:0] rc_prev(input logic [5:0] r);
    return {r[0] ^ r[5] ^ 1'b1, r[5:1]};
  endfunction

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm   <= S_IDLE;
      blk   <= '0;
      key   <= '0;
      rc    <= '0;
      step  <= '0;
      rnd   <= '0;
      cnt   <= '0;
      dataq <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      fsm   <= fsm_d;
      blk   <= blk_d;
      key   <= key_d;
      rc    <= rc_d;
      step  <= step_d;
      rnd   <= rnd_d;
      cnt   <= cnt_d;
      dataq <= dataq_d;
      done  <= done_d;
      busy  <= busy_d;
    end
  end

  // Next-state and datapath sequencing
  always_comb begin
    fsm_d   = fsm;
    blk_d   = blk;
    key_d   = key;
    rc_d    = rc;
    step_d  = step;
    rnd_d   = rnd;
    cnt_d   = cnt;
    dataq_d = dataq;
    done_d  = done;
    busy_d  = busy;

    case (fsm)
      S_IDLE: begin
        if (start) begin
          blk_d  = datai ^ keyi[127:64];
          key_d  = keyi;
          rc_d   = RC_INIT;
          step_d = STEP_LAST;
          rnd_d  = 2'd0;
          cnt_d  = 4'd0;
          done_d = 1'b0;
          busy_d = 1'b1;
          fsm_d  = S_IMC;
        end
      end

      S_IMC: begin
        blk_d = inv_mix(blk);
        cnt_d = cnt + 4'd1;
        if (cnt == IMC_LAST) begin
          cnt_d = 4'd0;
          fsm_d = S_ISR;
        end
      end

      S_ISR: begin
        blk_d = inv_shift(blk);
        cnt_d = 4'd0;
        fsm_d = S_ISB;
      end

      S_ISB: begin
        blk_d = nib_set(blk, cnt, inv_sbox(nib_get(blk, cnt)) ^ rc_const(cnt, rc));
        cnt_d = cnt + 4'd1;
        if (cnt == ISB_LAST) begin
          cnt_d = 4'd0;
          rc_d  = rc_prev(rc);
          if (rnd != RND_LAST) begin
            rnd_d = rnd + 2'd1;
            fsm_d = S_IMC;
          end else begin
            fsm_d = S_AK;
          end
        end
      end

      S_AK: begin
        blk_d = blk ^ (step[0] ? key[63:0] : key[127:64]);
        if (step == 4'd0) begin
          fsm_d = S_FIN;
        end else begin
          step_d = step - 4'd1;
          rnd_d  = 2'd0;
          fsm_d  = S_IMC;
        end
      end

      // Output stage: publish the plaintext one cycle after the last key addition
      S_FIN: begin
        dataq_d = blk;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        fsm_d   = S_IDLE;
      end

      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_led_serial_dec.sv
// Bench for led_serial_dec: a forward LED-128 model produces ciphertexts, a scoreboard checks plaintext and timing.
module tb_led_serial_dec;

  localparam int unsigned LAT = 1021;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] keyi;
  logic [63:0]  datai;
  logic [63:0]  dataq;
  logic         done;
  logic         busy;

  led_serial_dec dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .keyi  (keyi),
    .datai (datai),
    .dataq (dataq),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pt;
    int unsigned due;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc    = 0;
  int unsigned n_cmp  = 0;
  int unsigned n_err  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
      4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
      4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
      4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] xt(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  // Forward LED-128: AK(K1), then 12 steps of 4 rounds (AC, SC, SR, MCS) each followed by AK
  function automatic logic [63:0] led_enc(input logic [63:0] p, input logic [127:0] k);
    logic [3:0]  m[16];
    logic [3:0]  t[16];
    logic [3:0]  a0, a1, a2, a3;
    logic [63:0] s;
    logic [5:0]  rc;
    s  = p ^ k[127:64];
    rc = 6'h01;
    for (int stp = 0; stp < 12; stp++) begin
      for (int rr = 0; rr < 4; rr++) begin
        for (int i = 0; i < 16; i++) m[i] = 4'(s >> (60 - 4 * i));
        m[0]  ^= 4'h8;
        m[4]  ^= 4'h9;
        m[8]  ^= 4'h2;
        m[12] ^= 4'h3;
        m[1]  ^= {1'b0, rc[5:3]};
        m[5]  ^= {1'b0, rc[2:0]};
        m[9]  ^= {1'b0, rc[5:3]};
        m[13] ^= {1'b0, rc[2:0]};
        for (int i = 0; i < 16; i++) m[i] = sbox(m[i]);
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[4 * r + c] = m[4 * r + ((c + r) % 4)];
        for (int n = 0; n < 4; n++) begin
          for (int c = 0; c < 4; c++) begin
            a0 = t[c]; a1 = t[4 + c]; a2 = t[8 + c]; a3 = t[12 + c];
            t[c]      = a1;
            t[4 + c]  = a2;
            t[8 + c]  = a3;
            t[12 + c] = xt(xt(a0)) ^ a1 ^ xt(a2) ^ xt(a3);
          end
        end
        s = 64'd0;
        for (int i = 0; i < 16; i++) s = (s << 4) | {60'd0, t[i]};
        rc = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
      end
      s ^= (stp % 2 == 1) ? k[127:64] : k[63:0];
    end
    return s;
  endfunction

  // Drive start for one cycle from a negedge; accepted starts enqueue their expected result
  task automatic do_start(input logic [127:0] k, input logic [63:0] pt, input bit accept);
    exp_t e;
    start = 1'b1;
    keyi  = k;
    datai = led_enc(pt, k);
    if (accept) begin
      e.pt  = pt;
      e.due = cyc + 1 + LAT;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    keyi  = {$urandom, $urandom, $urandom, $urandom};
    datai = {$urandom, $urandom};
  endtask

  task automatic wait_done(input int unsigned maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done: no done within %0d cycles, expected done=1", maxc);
    end
  endtask

  // Monitor: pop and compare on each rising done
  logic        done_q   = 1'b0;
  int unsigned busy_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 with dataq %h, expected no result", dataq);
        end else begin
          e = sbq.pop_front();
          check("plaintext", dataq, e.pt);
          check("latency_cycle", 64'(cyc), 64'(e.due));
          check("busy_cycles", 64'(busy_cnt), 64'(LAT));
        end
      end
      busy_cnt = busy ? busy_cnt + 1 : 0;
      done_q   = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] K1  = 128'h29cdbaabf2fbe3467cc254f81be8e78d;
  localparam logic [127:0] K2  = 128'h66320db73158a35a255d051758e95ed4;
  localparam logic [127:0] K3  = 128'h0e827441213ddc8770e93ea141e1fc67;
  localparam logic [63:0]  P1  = 64'h67c6697351ff4aec;
  localparam logic [63:0]  P2  = 64'h765a2e63339fc99a;
  localparam logic [63:0]  P3  = 64'habb2cdc69bb45411;
  localparam logic [63:0]  P4  = 64'h0123456789abcdef;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    keyi  = '0;
    datai = '0;
    repeat (5) @(negedge clk);
    check("reset_dataq", dataq, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reference run with a stray start pulse at E0+300
    do_start(K1, P1, 1'b1);
    repeat (299) @(negedge clk);
    do_start(K2, P2, 1'b0);
    wait_done(LAT + 50);
    repeat (10) @(negedge clk);
    check("hold_done_1", {63'd0, done}, 64'd1);
    check("hold_dataq_1", dataq, P1);

    do_start(K2, P2, 1'b1);
    wait_done(LAT + 50);
    repeat (5) @(negedge clk);
    check("hold_dataq_2", dataq, P2);

    // Back-to-back: restart on the cycle after done
    do_start(K3, P3, 1'b1);
    wait_done(LAT + 50);
    do_start(K2, P4, 1'b1);
    check("b2b_done_drop", {63'd0, done}, 64'd0);
    check("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done(LAT + 50);

    // Abort with reset at E0+500
    do_start(K1, P2, 1'b1);
    repeat (499) @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    check("abort_dataq", dataq, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // All-zero key and plaintext with round-constant probes
    do_start(128'd0, 64'd0, 1'b1);
    check("rc_round47", 64'(dut.rc), 64'h04);
    repeat (21) @(negedge clk);
    check("rc_round46", 64'(dut.rc), 64'h22);
    repeat (21) @(negedge clk);
    check("rc_round45", 64'(dut.rc), 64'h11);
    repeat (958) @(negedge clk);
    check("rc_round0", 64'(dut.rc), 64'h01);
    wait_done(LAT + 50);
    repeat (3) @(negedge clk);

    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
